// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the RV64 instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic {
    S_REQ,
    S_WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_buffer.sv
// Fetch buffer: small synchronous FIFO of {pc, inst} entries with flush.
module fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [63:0] push_pc,
  input  logic [31:0] push_inst,
  input  logic        pop,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [63:0] head_pc,
  output logic [31:0] head_inst
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign head_pc   = mem_q[rd_ptr_q].pc;
  assign head_inst = mem_q[rd_ptr_q].inst;
  assign do_push   = push && !flush && !full;
  assign do_pop    = pop && !flush && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = '{pc: push_pc, inst: push_inst};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a time,
// buffers responses and presents {inst, if_pc} to the IF/ID register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned FB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic [63:0] if_pc,
  output logic        if_valid,
  output logic        if_flush
);

  localparam logic [63:0] ALIGN_MASK = {{62{1'b1}}, 2'b00};

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  req_pc_q, req_pc_d;
  logic         discard_q, discard_d;
  logic         req_fire;
  logic         fb_push, fb_pop, fb_full, fb_empty;
  logic [63:0]  head_pc;
  logic [31:0]  head_inst;

  // Gated by rst so no request is visible while reset is held.
  assign imem_req_valid = (state_q == S_REQ) && !fb_full && !rst;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign if_valid = !fb_empty;
  assign inst     = fb_empty ? NOP_INST : head_inst;
  assign if_pc    = fb_empty ? pc_q : head_pc;
  assign if_flush = redirect_valid;
  assign fb_pop   = if_valid && !stall;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    fb_push   = 1'b0;
    if (redirect_valid) begin
      // An accepted request or an in-flight one must have its response dropped.
      pc_d = redirect_pc & ALIGN_MASK;
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            state_d   = S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d   = S_WAIT;
            req_pc_d  = pc_q;
            pc_d      = pc_q + 64'd4;
            discard_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            fb_push   = !discard_q;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_buffer #(
    .DEPTH(FB_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (fb_push),
    .push_pc  (req_pc_q),
    .push_inst(imem_rsp_data),
    .pop      (fb_pop),
    .flush    (redirect_valid),
    .full     (fb_full),
    .empty    (fb_empty),
    .head_pc  (head_pc),
    .head_inst(head_inst)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized scoreboard bench for if_fetch_unit against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic [63:0] if_pc;
  logic        if_valid;
  logic        if_flush;

  if_fetch_unit #(
    .RESET_PC(RST_PC),
    .FB_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .inst          (inst),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .if_flush      (if_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model state: the fetch stream as seen by the memory interface.
  bit          outstanding;
  bit          discard;
  logic [63:0] exp_pc;
  logic [63:0] out_addr;
  logic [31:0] out_data;
  bit          in_reset;
  bit          release_pending;
  int unsigned stall_pct, redir_pct, ready_pct, rsp_pct;
  bit          fixed_en;
  logic [63:0] fixed_pc;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic knobs(input int unsigned st, input int unsigned rd,
                       input int unsigned ry, input int unsigned rs);
    stall_pct = st;
    redir_pct = rd;
    ready_pct = ry;
    rsp_pct   = rs;
  endtask

  task automatic cycle();
    logic fire;
    @(negedge clk);
    if (release_pending) begin
      rst             = 1'b0;
      release_pending = 1'b0;
      in_reset        = 1'b0;
      sb.delete();
      outstanding     = 1'b0;
      discard         = 1'b0;
      exp_pc          = RST_PC;
    end
    stall          = ($urandom_range(99) < stall_pct);
    redirect_valid = ($urandom_range(99) < redir_pct);
    if (fixed_en)              redirect_pc = fixed_pc;
    else if ($urandom_range(1)) redirect_pc = {32'h0, 16'h8000, 16'($urandom)};
    else                        redirect_pc = {$urandom, $urandom};
    imem_req_ready = ($urandom_range(99) < ready_pct);
    imem_rsp_valid = outstanding && ($urandom_range(99) < rsp_pct);
    imem_rsp_data  = imem_rsp_valid ? out_data : $urandom;
    #3;
    fire = imem_req_valid && imem_req_ready;
    if (redirect_valid) begin
      sb.delete();
      if (outstanding && imem_rsp_valid) outstanding = 1'b0;
      else if (outstanding)              discard     = 1'b1;
      if (fire) begin
        outstanding = 1'b1;
        discard     = 1'b1;
      end
      exp_pc = {redirect_pc[63:2], 2'b00};
    end else begin
      if (outstanding && imem_rsp_valid) begin
        if (!discard) sb.push_back('{pc: out_addr, inst: out_data});
        outstanding = 1'b0;
      end
      if (fire) begin
        outstanding = 1'b1;
        discard     = 1'b0;
        out_addr    = exp_pc;
        out_data    = $urandom;
        exp_pc      = exp_pc + 64'd4;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst            = 1'b1;
    in_reset       = 1'b1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    check64("rst_req_valid", imem_req_valid, 64'd0);
    check64("rst_if_valid", if_valid, 64'd0);
    check64("rst_inst", inst, NOP);
    check64("rst_if_pc", if_pc, RST_PC);
    repeat (n - 1) @(negedge clk);
    release_pending = 1'b1;
  endtask

  task automatic wait_outstanding(input string why);
    int k = 0;
    while (!outstanding && k < 50) begin
      cycle();
      k++;
    end
    if (!outstanding) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: got no accepted request expected one within 50 cycles", why);
    end
  endtask

  task automatic wait_almost_full(input string why);
    int k = 0;
    while (!(outstanding && sb.size() == DEPTH - 1) && k < 50) begin
      cycle();
      k++;
    end
    if (!(outstanding && sb.size() == DEPTH - 1)) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: got %0d buffered expected %0d plus in-flight", why, sb.size(), DEPTH - 1);
    end
  endtask

  // Monitor: compares the IF/ID-facing outputs against the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset) begin
        check64("if_flush", if_flush, redirect_valid);
        check64("req_valid", imem_req_valid, (!outstanding && sb.size() < DEPTH));
        if (imem_req_valid) check64("req_addr", imem_req_addr, exp_pc);
        check64("if_valid", if_valid, sb.size() != 0);
        if (sb.size() == 0) begin
          check64("nop_inst", inst, NOP);
          check64("idle_pc", if_pc, exp_pc);
        end else begin
          check64("inst", inst, sb[0].inst);
          check64("if_pc", if_pc, sb[0].pc);
          if (!stall && !redirect_valid) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    in_reset        = 1'b1;
    release_pending = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    outstanding     = 1'b0;
    discard         = 1'b0;
    exp_pc          = RST_PC;
    out_addr        = '0;
    out_data        = '0;
    fixed_en        = 1'b0;
    fixed_pc        = '0;
    knobs(0, 0, 100, 100);

    do_reset(3);
    repeat (12) cycle();

    knobs(100, 0, 100, 100);
    repeat (5) cycle();
    knobs(0, 0, 100, 100);
    repeat (6) cycle();

    knobs(0, 0, 100, 0);
    wait_outstanding("redir_wait_setup");
    fixed_en = 1'b1;
    fixed_pc = 64'h0000_0000_8000_1002;
    knobs(0, 100, 100, 0);
    cycle();
    knobs(0, 0, 100, 100);
    repeat (6) cycle();

    knobs(100, 0, 100, 100);
    wait_almost_full("redir_full_setup");
    fixed_pc = 64'h0000_0000_8000_2000;
    knobs(100, 100, 100, 100);
    cycle();
    knobs(0, 0, 100, 100);
    repeat (6) cycle();

    knobs(0, 0, 0, 100);
    repeat (4) cycle();
    knobs(0, 0, 100, 100);
    repeat (4) cycle();

    fixed_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    knobs(0, 100, 100, 100);
    cycle();
    knobs(0, 0, 100, 100);
    repeat (8) cycle();
    fixed_en = 1'b0;

    knobs(0, 0, 100, 0);
    wait_outstanding("reset_wait_setup");
    do_reset(2);
    knobs(0, 0, 100, 100);
    repeat (8) cycle();

    knobs(30, 5, 70, 60);
    repeat (3000) cycle();
    knobs(60, 10, 50, 40);
    repeat (2000) cycle();
    knobs(10, 2, 90, 90);
    repeat (2000) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
